// File: rtl/ram_wait_ctrl.sv
// ---------------------------------------------------------------------------
// ram_wait_ctrl
// Single-port synchronous word RAM with a request/Done handshake and a
// programmable number of wait states. An access is accepted only in IDLE. The
// address, write data and operation are captured at that point, so later input
// changes do not affect an access already in flight. The access commits on the
// edge that enters DONE. Done pulses for one cycle after that edge.
//
// Optional feature macro: RAM_PARITY_EN
//   When it is defined, each word stores an even-parity bit, and a read commit
//   updates ParityErr. When it is undefined, no parity is stored and ParityErr
//   stays 0.
//
// Ports
//   clock      in   1       rising-edge clock
//   clear      in   1       synchronous active-high reset (aborts any access)
//   Read       in   1       read request, sampled in IDLE only
//   Write      in   1       write request, sampled in IDLE only (wins over Read)
//   Address    in   ADDR_W  word address, captured on accept
//   BusMuxIn   in   DATA_W  write data, captured on accept
//   MDRMux     out  DATA_W  registered read data, changes only on read commit
//   Done       out  1       one-cycle completion pulse
//   Busy       out  1       registered, high while state != IDLE
//   ParityErr  out  1       read parity error (0 unless RAM_PARITY_EN)
// ---------------------------------------------------------------------------
module ram_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] BusMuxIn,
    output logic [DATA_W-1:0] MDRMux,
    output logic              Done,
    output logic              Busy,
    output logic              ParityErr
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Even-parity bit of a data word (the XOR of all its bits).
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    state_t              state_r, state_s;
    logic [3:0]          cnt_r, cnt_s;
    logic                op_wr_r, op_wr_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                done_r, done_s;
    logic                busy_r, busy_s;
    logic [DATA_W-1:0]   mdr_r, mdr_s;
    logic                perr_r, perr_s;

    logic                commit_s;
    logic                wr_en_s;
    logic                in_range_s;
    logic [IDX_W-1:0]    idx_s;
    logic [DATA_W-1:0]   rd_word_s;

    logic [DATA_W-1:0]   mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic                par_mem [DEPTH];
`endif

    // The range check and array index use the operation's address for this
    // cycle. When WAIT_STATES=0, the commit happens on the accept edge itself,
    // so that address comes straight from the inputs.
    assign in_range_s = ({1'b0, addr_s} < DEPTH_L);
    assign idx_s      = addr_s[IDX_W-1:0];
    assign rd_word_s  = mem[idx_s];

    // State register: FSM state, captured operation and all registered outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_wr_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            mdr_r   <= {DATA_W{1'b0}};
            perr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_wr_r <= op_wr_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            mdr_r   <= mdr_s;
            perr_r  <= perr_s;
        end
    end

    // Next-state logic: accept in IDLE, count wait states, and return to IDLE after DONE.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_wr_s = op_wr_r;
        addr_s  = addr_r;
        data_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (Read || Write) begin
                    // Write has priority; a simultaneous read is dropped.
                    op_wr_s = Write;
                    addr_s  = Address;
                    data_s  = BusMuxIn;
                    if (WAIT_STATES == 0) begin
                        state_s = ST_DONE;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and the commit strobes.
    always_comb begin
        done_s   = (state_r == ST_DONE);
        busy_s   = (state_s != ST_IDLE);
        commit_s = (state_s == ST_DONE) && (state_r != ST_DONE);
        // clear on the commit edge suppresses the pending write.
        wr_en_s  = commit_s && op_wr_s && in_range_s && !clear;
        mdr_s    = mdr_r;
        perr_s   = perr_r;
        if (commit_s && !op_wr_s) begin
            if (in_range_s) begin
                mdr_s  = rd_word_s;
`ifdef RAM_PARITY_EN
                perr_s = (par_mem[idx_s] != even_par(rd_word_s));
`else
                perr_s = 1'b0;
`endif
            end else begin
                // Out-of-range reads return zero and are never flagged.
                mdr_s  = {DATA_W{1'b0}};
                perr_s = 1'b0;
            end
        end else begin
            mdr_s  = mdr_r;
`ifdef RAM_PARITY_EN
            perr_s = perr_r;
`else
            perr_s = 1'b0;
`endif
        end
    end

    // Memory array write port. The array contents are not reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem[idx_s]     <= data_s;
`ifdef RAM_PARITY_EN
            par_mem[idx_s] <= even_par(data_s);
`endif
        end
    end

    assign MDRMux    = mdr_r;
    assign Done      = done_r;
    assign Busy      = busy_r;
    assign ParityErr = perr_r;

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Testbench for ram_wait_ctrl. Two instances share one stimulus stream:
// u0 has DEPTH=256 and WAIT_STATES=1, and u1 has DEPTH=512 and WAIT_STATES=3.
// A transaction-level model predicts Done, Busy, MDRMux and ParityErr for each
// instance. It uses accept-time arithmetic: the commit happens at accept+WS and
// Done goes high at accept+WS+1.
module tb_ram_wait_ctrl;

    logic        clock;
    logic        clear;
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] mdr0, mdr1;
    logic        done0, done1, busy0, busy1, perr0, perr1;

    int errors = 0;
    int checks = 0;

    ram_wait_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(1)) u0 (
        .clock(clock), .clear(clear), .Read(rd), .Write(wr), .Address(addr),
        .BusMuxIn(data), .MDRMux(mdr0), .Done(done0), .Busy(busy0), .ParityErr(perr0)
    );

    ram_wait_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(3)) u1 (
        .clock(clock), .clear(clear), .Read(rd), .Write(wr), .Address(addr),
        .BusMuxIn(data), .MDRMux(mdr1), .Done(done1), .Busy(busy1), .ParityErr(perr1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0] m_mem  [2][512];
    bit          m_val  [2][512];
    bit          m_par  [2][512];
    int          m_cyc = 0;
    int          m_done_at [2] = '{-2, -2};
    int          m_commit_at [2];
    bit          m_pend [2];
    bit          m_opw  [2];
    logic [8:0]  m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] m_mdr  [2];
    bit          m_mdr_ok [2];
    bit          m_perr [2];
    bit          m_perr_ok [2];
    bit          m_done [2];
    bit          m_busy [2];

    function automatic int ws_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int depth_of(int i);
        return (i == 0) ? 256 : 512;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_pend[i]    = 1'b0;
                m_done[i]    = 1'b0;
                m_busy[i]    = 1'b0;
                m_mdr[i]     = 32'h0;
                m_mdr_ok[i]  = 1'b1;
                m_perr[i]    = 1'b0;
                m_perr_ok[i] = 1'b1;
                m_done_at[i] = m_cyc;
            end else begin
                m_done[i] = (m_cyc == m_done_at[i]);
                if (m_cyc > m_done_at[i] && !m_pend[i] && (rd || wr)) begin
                    m_pend[i]      = 1'b1;
                    m_opw[i]       = wr;
                    m_addr[i]      = addr;
                    m_data[i]      = data;
                    m_commit_at[i] = m_cyc + ws_of(i);
                    m_done_at[i]   = m_cyc + ws_of(i) + 1;
                end
                if (m_pend[i] && m_cyc == m_commit_at[i]) begin
                    m_pend[i] = 1'b0;
                    if (m_opw[i]) begin
                        if (int'(m_addr[i]) < depth_of(i)) begin
                            m_mem[i][m_addr[i]] = m_data[i];
                            m_val[i][m_addr[i]] = 1'b1;
                            m_par[i][m_addr[i]] = ^m_data[i];
                        end
                    end else if (int'(m_addr[i]) >= depth_of(i)) begin
                        m_mdr[i] = 32'h0;  m_mdr_ok[i] = 1'b1;
                        m_perr[i] = 1'b0;  m_perr_ok[i] = 1'b1;
                    end else if (m_val[i][m_addr[i]]) begin
                        m_mdr[i]     = m_mem[i][m_addr[i]];
                        m_mdr_ok[i]  = 1'b1;
                        m_perr[i]    = (m_par[i][m_addr[i]] != ^m_mem[i][m_addr[i]]);
                        m_perr_ok[i] = 1'b1;
                    end else begin
                        m_mdr_ok[i]  = 1'b0;
                        m_perr_ok[i] = 1'b0;
                    end
`ifndef RAM_PARITY_EN
                    m_perr[i]    = 1'b0;
                    m_perr_ok[i] = 1'b1;
`endif
                end
                m_busy[i] = (m_cyc < m_done_at[i]);
            end
        end
        m_cyc++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("u0_done", {31'h0, done0}, {31'h0, m_done[0]});
        chk("u0_busy", {31'h0, busy0}, {31'h0, m_busy[0]});
        chk("u1_done", {31'h0, done1}, {31'h0, m_done[1]});
        chk("u1_busy", {31'h0, busy1}, {31'h0, m_busy[1]});
        if (m_mdr_ok[0]) chk("u0_mdr", mdr0, m_mdr[0]);
        if (m_mdr_ok[1]) chk("u1_mdr", mdr1, m_mdr[1]);
        if (m_perr_ok[0]) chk("u0_perr", {31'h0, perr0}, {31'h0, m_perr[0]});
        if (m_perr_ok[1]) chk("u1_perr", {31'h0, perr1}, {31'h0, m_perr[1]});
    endtask

    // One clock: active edge, model update, sample 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    // Pulse a request to u0 for one cycle, scramble the inputs, and wait for Done.
    task automatic do_op(input bit r, input bit w, input logic [8:0] a,
                         input logic [31:0] d, output int lat);
        rd = r; wr = w; addr = a; data = d;
        cycle();
        rd = 1'b0; wr = 1'b0; addr = 9'($urandom); data = $urandom;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!done0 && lat < 12);
        chk("u0_latency", lat, 32'd2);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          clr;
        bit          r;
        bit          w;
        logic [8:0]  a;
        logic [31:0] d;
        bit          e_done;
        bit          e_busy;
        bit          chk_mdr;
        logic [31:0] e_mdr;
    } vec_t;

    vec_t vt [12];

    initial begin
        int lat;
        int nd;

        vt[0]  = '{1'b1, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 9'h010, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[10] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b1, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[11] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};

        clear = 1'b1; rd = 1'b0; wr = 1'b0; addr = 9'h0; data = 32'h0;

        // Reset, first read, and write-then-read of 0xDEADBEEF.
        for (int k = 0; k < 12; k++) begin
            clear = vt[k].clr; rd = vt[k].r; wr = vt[k].w;
            addr = vt[k].a; data = vt[k].d;
            cycle();
            chk($sformatf("tbl%0d_done", k), {31'h0, done0}, {31'h0, vt[k].e_done});
            chk($sformatf("tbl%0d_busy", k), {31'h0, busy0}, {31'h0, vt[k].e_busy});
            if (vt[k].chk_mdr) chk($sformatf("tbl%0d_mdr", k), mdr0, vt[k].e_mdr);
        end
        clear = 1'b0; rd = 1'b0; wr = 1'b0;

        // Read and Write together: the write wins and no read result appears.
        do_op(1'b1, 1'b1, 9'h020, 32'h12345678, lat);
        chk("rw_no_read", mdr0, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 9'h020, 32'h0, lat);
        chk("rw_readback", mdr0, 32'h12345678);

        // A read pulse while Busy is ignored.
        rd = 1'b0; wr = 1'b1; addr = 9'h040; data = 32'h5A5A5A5A;
        cycle();
        rd = 1'b1; wr = 1'b0; addr = 9'h011;
        cycle();
        nd = int'(done0);
        rd = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            nd += int'(done0);
        end
        chk("busy_one_done", nd, 32'd1);
        chk("busy_mdr_held", mdr0, 32'h12345678);

        // Out-of-range address on the DEPTH=256 instance.
        do_op(1'b0, 1'b1, 9'h0FF, 32'h11111111, lat);
        do_op(1'b0, 1'b1, 9'h1FF, 32'hAAAA5555, lat);
        do_op(1'b1, 1'b0, 9'h1FF, 32'h0, lat);
        chk("oor_read_zero", mdr0, 32'h0);
        do_op(1'b1, 1'b0, 9'h0FF, 32'h0, lat);
        chk("oor_no_alias", mdr0, 32'h11111111);

        // clear on the commit edge aborts the pending write.
        do_op(1'b0, 1'b1, 9'h030, 32'h0BADF00D, lat);
        wr = 1'b1; addr = 9'h030; data = 32'h0000FFFF;
        cycle();
        wr = 1'b0; clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_busy", {31'h0, busy0}, 32'h0);
        chk("clr_mdr", mdr0, 32'h0);
        do_op(1'b1, 1'b0, 9'h030, 32'h0, lat);
        chk("clr_old_data", mdr0, 32'h0BADF00D);

`ifdef RAM_PARITY_EN
        // A corrupted stored parity bit is flagged on the read.
        do_op(1'b0, 1'b1, 9'h050, 32'h00000007, lat);
        u0.par_mem[8'h50] = ~u0.par_mem[8'h50];
        m_par[0][9'h050]  = ~m_par[0][9'h050];
        do_op(1'b1, 1'b0, 9'h050, 32'h0, lat);
        chk("parity_flag", {31'h0, perr0}, 32'h1);
`endif

        // Random traffic checked against the model on every cycle.
        for (int n = 0; n < 4000; n++) begin
            int pick;
            clear = ($urandom_range(0, 99) == 0);
            rd    = ($urandom_range(0, 2) == 0);
            wr    = ($urandom_range(0, 2) == 0);
            pick  = $urandom_range(0, 3);
            if (pick == 0)      addr = 9'($urandom);
            else if (pick == 1) addr = 9'(9'h0F8 + 9'($urandom_range(0, 15)));
            else                addr = 9'($urandom_range(0, 15));
            data  = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
